align_operands: RTL and testbench

ALIGN_OPERANDS -- requirements
Module: align_operands

---
 rtl/fpu_align_pkg.sv | 26 ++
 rtl/sticky_shift_right.sv | 24 ++
 rtl/align_operands.sv | 158 +++++++++++++++
 tb/tb_align_operands.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_align_pkg.sv
// Shared types and width derivation for the FP operand alignment stage.
// Holds the alignment FSM encoding and exponent/fraction/GRS widths.
package fpu_align_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int GRS_W = 3;

  function automatic int exp_w(input int w);
    return (w == 64) ? 11 : 8;
  endfunction

  function automatic int frac_w(input int w);
    return (w == 64) ? 52 : 23;
  endfunction

  // hidden bit + fraction + guard/round/sticky
  function automatic int mant_w(input int w);
    return frac_w(w) + 1 + GRS_W;
  endfunction

endpackage

// File: rtl/sticky_shift_right.sv
// Right shift of an aligned mantissa; every bit shifted out is
// ORed into the result LSB so rounding still sees it as sticky.
module sticky_shift_right
  import fpu_align_pkg::*;
#(
  parameter int MW  = 27,
  parameter int SHW = 8
) (
  input  logic [MW-1:0]  mant_i,
  input  logic [SHW-1:0] sh_i,
  output logic [MW-1:0]  mant_o
);

  logic [MW-1:0] lost_mask;
  logic          lost;

  always_comb begin
    lost_mask = ~({MW{1'b1}} << sh_i);
    lost      = |(mant_i & lost_mask);
    mant_o    = mant_i >> sh_i;
    mant_o[0] = mant_o[0] | lost;
  end

endmodule

// File: rtl/align_operands.sv
// Operand swap/compare and mantissa alignment ahead of an FP adder.
// ALIGN_FAST_SHIFT_EN: defined -> one-cycle barrel shift, else 1 bit/cycle.
module align_operands
  import fpu_align_pkg::*;
#(
  parameter int  W  = 32,
  localparam int EW = exp_w(W),
  localparam int SW = frac_w(W),
  localparam int MW = mant_w(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  Data_X,
  input  logic [W-1:0]  Data_Y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          sign_o,
  output logic [EW-1:0] exp_o,
  output logic [MW-1:0] mant_large_o,
  output logic [MW-1:0] mant_small_o,
  output logic          eff_sub_o,
  output logic          swap_o
);

  localparam logic [EW-1:0] MW_E = EW'(MW);

  state_e        state_q, state_d;
  logic [EW-1:0] cnt_q, cnt_d;
  logic          sign_q, sign_d;
  logic [EW-1:0] exp_q, exp_d;
  logic [MW-1:0] ml_q, ml_d;
  logic [MW-1:0] ms_q, ms_d;
  logic          eff_q, eff_d;
  logic          swap_q, swap_d;

  logic          swap_n;
  logic [W-1:0]  big;
  logic [W-2:0]  sml;
  logic [EW-1:0] eb, es, d_n;
  logic [SW-1:0] fb, fs;
  logic [MW-1:0] ml_n, ms_n, ms_sh;
  logic [EW-1:0] sh_amt;

  always_comb begin
    swap_n = Data_Y[W-2:0] > Data_X[W-2:0];
    big    = swap_n ? Data_Y : Data_X;
    sml    = swap_n ? Data_X[W-2:0] : Data_Y[W-2:0];
    eb     = big[W-2 -: EW];
    es     = sml[W-2 -: EW];
    fb     = big[SW-1:0];
    fs     = sml[SW-1:0];
    ml_n   = {|eb, fb, {GRS_W{1'b0}}};
    ms_n   = {|es, fs, {GRS_W{1'b0}}};
    d_n    = eb - es;
  end

`ifdef ALIGN_FAST_SHIFT_EN
  assign sh_amt = cnt_q;
`else
  assign sh_amt = EW'(1);
`endif

  sticky_shift_right #(
    .MW  (MW),
    .SHW (EW)
  ) u_shift (
    .mant_i (ms_q),
    .sh_i   (sh_amt),
    .mant_o (ms_sh)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      ml_q    <= '0;
      ms_q    <= '0;
      eff_q   <= 1'b0;
      swap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      ml_q    <= ml_d;
      ms_q    <= ms_d;
      eff_q   <= eff_d;
      swap_q  <= swap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (in_valid) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == '0) state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    sign_d = sign_q;
    exp_d  = exp_q;
    ml_d   = ml_q;
    ms_d   = ms_q;
    eff_d  = eff_q;
    swap_d = swap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d = big[W-1];
          exp_d  = eb;
          ml_d   = ml_n;
          eff_d  = Data_X[W-1] ^ Data_Y[W-1];
          swap_d = swap_n;
          // far apart: everything collapses into sticky
          if (d_n >= MW_E) begin
            ms_d  = {{(MW-1){1'b0}}, |ms_n};
            cnt_d = '0;
          end else begin
            ms_d  = ms_n;
            cnt_d = d_n;
          end
        end
      end
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          ms_d = ms_sh;
`ifdef ALIGN_FAST_SHIFT_EN
          cnt_d = '0;
`else
          cnt_d = cnt_q - EW'(1);
`endif
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  assign sign_o       = sign_q;
  assign exp_o        = exp_q;
  assign mant_large_o = ml_q;
  assign mant_small_o = ms_q;
  assign eff_sub_o    = eff_q;
  assign swap_o       = swap_q;

endmodule

// File: tb/tb_align_operands.sv
// Bench for align_operands (W=32): directed table, random vs model,
// DONE back-pressure and mid-shift reset sequences.
module tb_align_operands;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Data_X;
  logic [31:0] Data_Y;
  logic        out_valid;
  logic        out_ready;
  logic        sign_o;
  logic [7:0]  exp_o;
  logic [26:0] mant_large_o;
  logic [26:0] mant_small_o;
  logic        eff_sub_o;
  logic        swap_o;

  int total = 0;
  int bad   = 0;

  align_operands #(.W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .Data_X       (Data_X),
    .Data_Y       (Data_Y),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .sign_o       (sign_o),
    .exp_o        (exp_o),
    .mant_large_o (mant_large_o),
    .mant_small_o (mant_small_o),
    .eff_sub_o    (eff_sub_o),
    .swap_o       (swap_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ALIGN_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [7:0]  e;
    logic [26:0] ml;
    logic [26:0] ms;
    logic        s;
    logic        sw;
    logic        es;
    int          lat;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Alignment from the rules: magnitudes as integers, sticky by remainder
  function automatic void ref_model(
    input  logic [31:0] x, input logic [31:0] y,
    output logic [7:0] e, output logic [26:0] ml, output logic [26:0] ms,
    output logic s, output logic sw, output logic es, output int lat);
    longint unsigned mx, my, a, b, p, rem;
    logic [31:0] lg, sm;
    int el, esm, d;
    mx = longint'(x[30:0]);
    my = longint'(y[30:0]);
    sw = (my > mx);
    lg = sw ? y : x;
    sm = sw ? x : y;
    el = int'(lg[30:23]);
    esm = int'(sm[30:23]);
    d = el - esm;
    a = ((el != 0) ? 64'd8388608 : 64'd0) + longint'(lg[22:0]);
    b = ((esm != 0) ? 64'd8388608 : 64'd0) + longint'(sm[22:0]);
    a = a * 8;
    b = b * 8;
    if (d >= 27) begin
      b = (b != 0) ? 64'd1 : 64'd0;
    end else begin
      p = 64'd1 << d;
      rem = b % p;
      b = b / p;
      if (rem != 0) b = b | 64'd1;
    end
    e = lg[30:23];
    ml = a[26:0];
    ms = b[26:0];
    s = lg[31];
    es = x[31] ^ y[31];
    if (d == 0 || d >= 27) lat = 1;
    else lat = FAST ? 2 : d + 1;
  endfunction

  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        output int lat);
    @(negedge clk);
    Data_X = x;
    Data_Y = y;
    in_valid = 1'b1;
    chk("accept_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic cmp_out(input string t, input vec_t v, input int lat);
    chk({t, "_lat"}, 64'(lat), 64'(v.lat));
    chk({t, "_exp"}, 64'(exp_o), 64'(v.e));
    chk({t, "_ml"}, 64'(mant_large_o), 64'(v.ml));
    chk({t, "_ms"}, 64'(mant_small_o), 64'(v.ms));
    chk({t, "_sign"}, 64'(sign_o), 64'(v.s));
    chk({t, "_swap"}, 64'(swap_o), 64'(v.sw));
    chk({t, "_effsub"}, 64'(eff_sub_o), 64'(v.es));
  endtask

  task automatic finish_op(input string t);
    @(posedge clk);
    #1;
    chk({t, "_idle_ready"}, 64'(in_ready), 64'd1);
    chk({t, "_idle_valid"}, 64'(out_valid), 64'd0);
  endtask

  task automatic model_op(input string t, input logic [31:0] x,
                          input logic [31:0] y);
    vec_t v;
    int lat;
    v.x = x;
    v.y = y;
    ref_model(x, y, v.e, v.ml, v.ms, v.s, v.sw, v.es, v.lat);
    run_op(x, y, lat);
    cmp_out(t, v, lat);
    finish_op(t);
  endtask

  initial begin
    int lat;
    logic [31:0] x, y;
    logic [7:0] ex, ey;
    logic [7:0] snap_e;
    logic [26:0] snap_ml, snap_ms;
    logic snap_sw;

    tbl[0] = '{32'h40400000, 32'h3F800000, 8'h80, 27'h6000000,
               27'h2000000, 1'b0, 1'b0, 1'b0, 2};
    tbl[1] = '{32'h3F800000, 32'hC0400000, 8'h80, 27'h6000000,
               27'h2000000, 1'b1, 1'b1, 1'b1, 2};
    tbl[2] = '{32'h4D800000, 32'h3F800000, 8'h9B, 27'h4000000,
               27'h0000001, 1'b0, 1'b0, 1'b0, 1};
    tbl[3] = '{32'h3F800000, 32'h3F800000, 8'h7F, 27'h4000000,
               27'h4000000, 1'b0, 1'b0, 1'b0, 1};

    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    Data_X = '0;
    Data_Y = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_exp", 64'(exp_o), 64'd0);
    chk("rst_ml", 64'(mant_large_o), 64'd0);
    chk("rst_ms", 64'(mant_small_o), 64'd0);
    chk("rst_flags", 64'({sign_o, swap_o, eff_sub_o}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 4; i++) begin
      run_op(tbl[i].x, tbl[i].y, lat);
      cmp_out($sformatf("vec%0d", i), tbl[i], lat);
      finish_op($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 40; i++) begin
      if (i % 4 == 0) begin
        x = $urandom;
        y = $urandom;
      end else begin
        ex = 8'($urandom_range(0, 254));
        ey = (int'(ex) > 30) ? ex - 8'($urandom_range(0, 30)) : 8'd0;
        x = {1'($urandom), ex, 23'($urandom)};
        y = {1'($urandom), ey, 23'($urandom)};
        if (i % 3 == 0) begin
          x = y;
          y = {1'($urandom), ex, 23'($urandom)};
        end
      end
      model_op($sformatf("rnd%0d", i), x, y);
    end

    // back-pressure in DONE with in_valid pulsing
    out_ready = 1'b0;
    run_op(32'h40400000, 32'h3F800000, lat);
    cmp_out("hold", tbl[0], lat);
    snap_e = exp_o;
    snap_ml = mant_large_o;
    snap_ms = mant_small_o;
    snap_sw = swap_o;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      Data_X = 32'h3F800000;
      Data_Y = 32'hC1000000;
      @(posedge clk);
      #1;
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_ready", 64'(in_ready), 64'd0);
      chk("hold_exp", 64'(exp_o), 64'(snap_e));
      chk("hold_mant",
          64'({snap_ml, snap_ms, snap_sw}) ^ 64'({mant_large_o,
          mant_small_o, swap_o}), 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_release_ready", 64'(in_ready), 64'd1);
    chk("hold_release_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("hold_no_accept", 64'(in_ready), 64'd1);
    chk("hold_exp_kept", 64'(exp_o), 64'(snap_e));

    // reset in the middle of a d=20 alignment
    out_ready = 1'b0;
    @(negedge clk);
    Data_X = 32'h49800000;
    Data_Y = 32'h3F800000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_exp", 64'(exp_o), 64'h93);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_exp", 64'(exp_o), 64'd0);
    chk("mid_rst_ml", 64'(mant_large_o), 64'd0);
    chk("mid_rst_ms", 64'(mant_small_o), 64'd0);
    chk("mid_rst_flags", 64'({sign_o, swap_o, eff_sub_o}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    model_op("post_rst", 32'h49800000, 32'h3F800000);
    model_op("post_rst2", 32'h3F800000, 32'hC0400000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
